// File: rtl/nv_blkbox_sink_misr.sv
// ============================================================================
// Module  : nv_blkbox_sink_misr
// Brief   : Keep-alive sink that registers all channels and folds them into a
//           MISR signature, readable as a snapshot over a four-phase handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nv_blkbox_sink_misr #(
    parameter int               WIDTH = 8,
    parameter int               NCH   = 4,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 sink_en,
    input  logic [NCH-1:0]       sink_ch_mask,
    input  logic [NCH*WIDTH-1:0] sink_a,
    output logic [NCH*WIDTH-1:0] sink_b,
    input  logic                 sig_clr,
    output logic [SIG_W-1:0]     sig_out,
    input  logic                 snap_req,
    output logic                 snap_ack,
    output logic [SIG_W-1:0]     snap_sig,
    output logic [15:0]          snap_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } snap_state_t;

    logic [NCH*WIDTH-1:0] r_b_q;
    logic [SIG_W-1:0]     r_sig_q,      w_sig_d;
    logic [15:0]          r_cnt_q,      w_cnt_d;
    snap_state_t          r_state_q,    w_state_d;
    logic [SIG_W-1:0]     r_snap_sig_q, w_snap_sig_d;
    logic [15:0]          r_snap_cnt_q, w_snap_cnt_d;

    logic [WIDTH-1:0]     w_fold_ch;
    logic [SIG_W-1:0]     w_fold;
    logic [SIG_W-1:0]     w_sig_step;
    logic                 w_sample;

    always_comb begin
        w_fold_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sink_ch_mask[i]) begin
                w_fold_ch = w_fold_ch ^ sink_a[i*WIDTH +: WIDTH];
            end
        end
        w_fold = SIG_W'(w_fold_ch);
    end

    assign w_sample   = sink_en && (sink_ch_mask != '0);
    assign w_sig_step = {r_sig_q[SIG_W-2:0], 1'b0}
                      ^ (r_sig_q[SIG_W-1] ? POLY : '0)
                      ^ w_fold;

    // Clear has priority over a sample presented in the same cycle.
    always_comb begin
        w_sig_d = r_sig_q;
        w_cnt_d = r_cnt_q;
        if (sig_clr) begin
            w_sig_d = SEED;
            w_cnt_d = '0;
        end else if (w_sample) begin
            w_sig_d = w_sig_step;
            if (r_cnt_q != 16'hFFFF) begin
                w_cnt_d = r_cnt_q + 16'd1;
            end
        end
    end

    // Capture uses the pre-edge signature/count, so a same-edge clear is not seen.
    always_comb begin
        w_state_d    = r_state_q;
        w_snap_sig_d = r_snap_sig_q;
        w_snap_cnt_d = r_snap_cnt_q;
        case (r_state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    w_snap_sig_d = r_sig_q;
                    w_snap_cnt_d = r_cnt_q;
                    w_state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!snap_req) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_b_q        <= '0;
            r_sig_q      <= SEED;
            r_cnt_q      <= '0;
            r_state_q    <= ST_IDLE;
            r_snap_sig_q <= '0;
            r_snap_cnt_q <= '0;
        end else begin
            r_b_q        <= sink_a;
            r_sig_q      <= w_sig_d;
            r_cnt_q      <= w_cnt_d;
            r_state_q    <= w_state_d;
            r_snap_sig_q <= w_snap_sig_d;
            r_snap_cnt_q <= w_snap_cnt_d;
        end
    end

    assign sink_b   = r_b_q;
    assign sig_out  = r_sig_q;
    assign snap_ack = (r_state_q == ST_HOLD);
    assign snap_sig = r_snap_sig_q;
    assign snap_cnt = r_snap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nv_blkbox_sink_misr.sv
// ============================================================================
// Module  : tb_nv_blkbox_sink_misr
// Brief   : Scoreboard bench for nv_blkbox_sink_misr with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nv_blkbox_sink_misr;

    localparam logic [15:0] C_SEED = 16'hFFFF;
    localparam int          C_POLY = 'h1021;

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rst = 1'b1;
    logic        sink_en        = 1'b0;
    logic [3:0]  sink_ch_mask   = '0;
    logic [31:0] sink_a         = '0;
    logic [31:0] sink_b;
    logic        sig_clr        = 1'b0;
    logic [15:0] sig_out;
    logic        snap_req       = 1'b0;
    logic        snap_ack;
    logic [15:0] snap_sig;
    logic [15:0] snap_cnt;

    nv_blkbox_sink_misr dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .sink_en        (sink_en),
        .sink_ch_mask   (sink_ch_mask),
        .sink_a         (sink_a),
        .sink_b         (sink_b),
        .sig_clr        (sig_clr),
        .sig_out        (sig_out),
        .snap_req       (snap_req),
        .snap_ack       (snap_ack),
        .snap_sig       (snap_sig),
        .snap_cnt       (snap_cnt)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    typedef struct {
        logic [31:0] b;
        logic [15:0] sig;
        logic        ack;
        logic [15:0] ssig;
        logic [15:0] scnt;
    } exp_t;

    exp_t        cq[$];
    logic [31:0] snapq[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Behavioural model state
    logic [15:0] m_sig  = C_SEED;
    int          m_cnt  = 0;
    logic        m_hold = 1'b0;
    logic [15:0] m_ssig = '0;
    logic [15:0] m_scnt = '0;
    logic [31:0] m_b    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_fold(input logic [31:0] a, input logic [3:0] m);
        int acc = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) acc = acc ^ ((a >> (8 * ch)) & 'hFF);
        end
        return acc;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] s, input int fold);
        int v;
        v = (int'(s) * 2) % 65536;
        if (s >= 16'h8000) v = v ^ C_POLY;
        v = v ^ fold;
        return v[15:0];
    endfunction

    task automatic model_reset();
        m_sig  = C_SEED;
        m_cnt  = 0;
        m_hold = 1'b0;
        m_ssig = '0;
        m_scnt = '0;
        m_b    = '0;
        cq.delete();
        snapq.delete();
    endtask

    // Predict one clock edge from the current inputs, then apply it.
    task automatic cycle();
        if (!m_hold && snap_req) begin
            m_ssig = m_sig;
            m_scnt = m_cnt[15:0];
            snapq.push_back({m_ssig, m_scnt});
            m_hold = 1'b1;
        end else if (m_hold && !snap_req) begin
            m_hold = 1'b0;
        end
        if (sig_clr) begin
            m_sig = C_SEED;
            m_cnt = 0;
        end else if (sink_en && sink_ch_mask != 0) begin
            m_sig = ref_step(m_sig, ref_fold(sink_a, sink_ch_mask));
            if (m_cnt < 65535) m_cnt++;
        end
        m_b = sink_a;
        @(posedge nvdla_core_clk);
        cq.push_back('{m_b, m_sig, m_hold, m_ssig, m_scnt});
        #1;
    endtask

    task automatic do_reset();
        nvdla_core_rst = 1'b1;
        model_reset();
        repeat (2) @(negedge nvdla_core_clk);
        #2 nvdla_core_rst = 1'b0;
    endtask

    // Monitor: pops one expectation per cycle and one per snapshot acknowledge.
    initial begin : monitor
        exp_t        e;
        logic [31:0] s;
        logic        prev_ack = 1'b0;
        forever begin
            @(negedge nvdla_core_clk);
            if (nvdla_core_rst) begin
                prev_ack = 1'b0;
            end else begin
                if (cq.size() > 0) begin
                    e = cq.pop_front();
                    chk("sink_b",   sink_b,   e.b);
                    chk("sig_out",  {16'h0, sig_out},  {16'h0, e.sig});
                    chk("snap_ack", {31'h0, snap_ack}, {31'h0, e.ack});
                    chk("snap_sig", {16'h0, snap_sig}, {16'h0, e.ssig});
                    chk("snap_cnt", {16'h0, snap_cnt}, {16'h0, e.scnt});
                end
                if (snap_ack && !prev_ack) begin
                    if (snapq.size() == 0) begin
                        chk("snap_unexpected_capture", 32'h1, 32'h0);
                    end else begin
                        s = snapq.pop_front();
                        chk("capture", {snap_sig, snap_cnt}, s);
                    end
                end
                prev_ack = snap_ack;
            end
        end
    end

    initial begin : stim
        do_reset();
        chk("rst_sig_out",  {16'h0, sig_out},  {16'h0, C_SEED});
        chk("rst_snap_ack", {31'h0, snap_ack}, 32'h0);
        chk("rst_sink_b",   sink_b,            32'h0);
        chk("rst_snap_sig", {16'h0, snap_sig}, 32'h0);
        chk("rst_snap_cnt", {16'h0, snap_cnt}, 32'h0);
        repeat (5) cycle();
        chk("idle_sig_out", {16'h0, sig_out}, 32'h0000FFFF);

        // Four-channel fold
        sink_a = 32'h08040201; sink_ch_mask = 4'hF; sink_en = 1'b1;
        cycle();
        sink_en = 1'b0;
        chk("fold4_sig", {16'h0, sig_out}, 32'h0000EFD0);
        chk("fold4_b",   sink_b,           32'h08040201);

        // Capture with same-edge clear and sample
        sig_clr = 1'b1; sink_en = 1'b1; snap_req = 1'b1;
        cycle();
        sig_clr = 1'b0; sink_en = 1'b0;
        chk("clr_snap_sig", {16'h0, snap_sig}, 32'h0000EFD0);
        chk("clr_snap_cnt", {16'h0, snap_cnt}, 32'h00000001);
        chk("clr_sig_out",  {16'h0, sig_out},  32'h0000FFFF);
        chk("clr_ack",      {31'h0, snap_ack}, 32'h1);
        cycle();
        snap_req = 1'b0;
        cycle();
        chk("ack_fall", {31'h0, snap_ack}, 32'h0);
        snap_req = 1'b1;
        cycle();
        chk("clr_count_zero", {16'h0, snap_cnt}, 32'h0);
        snap_req = 1'b0;
        cycle();

        // Level held high: single capture while sampling continues
        snap_req = 1'b1;
        repeat (10) begin
            sink_en = 1'b1; sink_a = $urandom; sink_ch_mask = 4'($urandom) | 4'h1;
            cycle();
        end
        snap_req = 1'b0; cycle();
        snap_req = 1'b1; cycle();
        snap_req = 1'b0; sink_en = 1'b0; cycle();

        // Single-channel fold from reset
        do_reset();
        sink_a = 32'h08040201; sink_ch_mask = 4'h1; sink_en = 1'b1;
        cycle();
        sink_en = 1'b0;
        chk("fold1_sig", {16'h0, sig_out}, 32'h0000EFDE);
        snap_req = 1'b1;
        cycle();
        chk("fold1_cnt", {16'h0, snap_cnt}, 32'h1);

        // Asynchronous reset while in HOLD, request left high
        cycle();
        nvdla_core_rst = 1'b1;
        #1;
        chk("arst_ack",      {31'h0, snap_ack}, 32'h0);
        chk("arst_snap_sig", {16'h0, snap_sig}, 32'h0);
        chk("arst_snap_cnt", {16'h0, snap_cnt}, 32'h0);
        chk("arst_sig_out",  {16'h0, sig_out},  32'h0000FFFF);
        model_reset();
        @(negedge nvdla_core_clk);
        #2 nvdla_core_rst = 1'b0;
        cycle();
        chk("arst_recapture_ack", {31'h0, snap_ack}, 32'h1);
        snap_req = 1'b0;
        cycle();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            sink_en      = ($urandom_range(0, 3) != 0);
            sink_ch_mask = 4'($urandom);
            sink_a       = $urandom;
            sig_clr      = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0) snap_req = ~snap_req;
            cycle();
        end
        sig_clr = 1'b0; snap_req = 1'b0; cycle();

        // Count saturation
        sig_clr = 1'b1; cycle(); sig_clr = 1'b0;
        sink_en = 1'b1; sink_ch_mask = 4'h1;
        for (int i = 0; i < 70000; i++) begin
            sink_a = $urandom;
            cycle();
        end
        snap_req = 1'b1;
        cycle();
        chk("sat_cnt", {16'h0, snap_cnt}, 32'h0000FFFF);
        snap_req = 1'b0; sink_en = 1'b0;
        repeat (2) cycle();

        @(negedge nvdla_core_clk);
        #1;
        chk("captures_pending", snapq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nv_blkbox_sink_misr.md
# nv_blkbox_sink_misr

Parametrised, multi-channel keep-alive sink for logic that has no functional consumer (spare ports, debug taps, unconnected sub-block outputs). It registers every channel to a passthrough output so the logic cannot be optimised away, and folds all enabled channels into a multiple-input signature register (MISR). The signature and a sample count can be read back as a stable snapshot over a four-phase handshake, so tapped logic remains observable in silicon test.

## Interface
- WIDTH, 8, bits per channel
- NCH, 4, number of channels (≥1)
- SIG_W, 16, signature width (≥ WIDTH)
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits)
- SEED, 16'hFFFF, signature value after reset or clear
- nvdla_core_clk  in  1  clock
- nvdla_core_rst  in  1  reset, asynchronous, active-high
- sink_en  in  1  global sample enable
- sink_ch_mask  in  NCH  per-channel fold enable; bit i gates channel i
- sink_a  in  NCH*WIDTH  channel data; channel i at [i*WIDTH +: WIDTH]
- sink_b  out  NCH*WIDTH  registered copy of sink_a
- sig_clr  in  1  synchronous clear of signature and count
- sig_out  out  SIG_W  live signature
- snap_req  in  1  snapshot request (level, four-phase)
- snap_ack  out  1  snapshot acknowledge
- snap_sig  out  SIG_W  captured signature
- snap_cnt  out  16  captured sample count

## Operation
- Reset values: sink_b=0, sig_out=SEED, sample count=0, snap_ack=0, snap_sig=0, snap_cnt=0, FSM=IDLE.
- Passthrough: sink_b <= sink_a every cycle, independent of sink_en, mask and clear.
- fold = XOR over i of (sink_ch_mask[i] ? channel i : 0), zero-extended to SIG_W.
- Sample fires when sink_en=1 and sink_ch_mask≠0.
- MISR step on sample: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
- Count: +1 per sample, saturates at 16'hFFFF, no wrap.
- No sample: sig and count hold.
- sig_clr=1: sig<=SEED, count<=0. Clear wins over a same-cycle sample.
- Snapshot FSM, two states:
  - IDLE: snap_ack=0. snap_req=1 → load snap_sig<=sig, snap_cnt<=count (register values before this edge's update/clear), go HOLD.
  - HOLD: snap_ack=1, snap regs frozen. snap_req=0 → go IDLE.
  - A new capture requires snap_req to return low first; a level held high never re-captures.
- Signature and count keep updating during HOLD; only the snap registers are frozen.

## Timing
- sink_b: 1-cycle latency.
- sig_out/count reflect a sample at the first edge after it is presented.
- snap_req high at edge k in IDLE → snap_ack=1 and snap values valid after edge k; snap_sig equals sig_out as seen just before edge k.
- snap_req low at edge m in HOLD → snap_ack=0 after edge m; the earliest next capture is at edge m+1.
- Reset asserted mid-handshake: all outputs go to their reset values asynchronously and the FSM goes to IDLE. A still-high snap_req after reset release causes a capture at the first edge.
- Capture and sig_clr at the same edge: the snapshot holds the pre-clear value, and sig_out reads SEED afterwards.

## Test plan
- Reset, then idle 5 cycles with sink_en=0 → sig_out=16'hFFFF, snap_ack=0, sink_b=0.
- sink_a={8'h08,8'h04,8'h02,8'h01}, mask=4'hF, sink_en=1 for one cycle → sig_out=16'hEFD0, count=1. Same data with mask=4'h1 from reset → 16'hEFDE. sink_b equals sink_a one cycle later in both cases.
- Hold sink_en=1 for 70000 cycles, then snapshot → snap_cnt=16'hFFFF (saturated).
- sig_clr=1 and sink_en=1 in the same cycle as snap_req rises with sig_out=16'hEFD0 → snap_sig=16'hEFD0, sig_out=16'hFFFF, count=0. snap_ack rises one edge later and stays high until snap_req falls.
- snap_req held high for 10 cycles while samples continue → exactly one capture and snap_sig stable. Toggle req low then high → second capture.
- Assert nvdla_core_rst asynchronously during HOLD → snap_ack, snap_sig and snap_cnt drop to 0 immediately, and sig_out=16'hFFFF.
